// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: funct3 codes, state encoding,
// and the request error classifier used at acceptance.
package lsu_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_STORE  = 3'd2;
  localparam logic [2:0] ST_RMW_RD = 3'd3;
  localparam logic [2:0] ST_RMW_WR = 3'd4;
  localparam logic [2:0] ST_ERR    = 3'd5;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    LOAD   = ST_LOAD,
    STORE  = ST_STORE,
    RMW_RD = ST_RMW_RD,
    RMW_WR = ST_RMW_WR,
    ERR    = ST_ERR
  } lsu_state_e;

  // Misaligned halfword/word, reserved funct3, or unsigned-store encodings.
  function automatic logic req_is_err(input logic we, input logic [2:0] f3,
                                      input logic [1:0] a);
    logic e;
    case (f3)
      F3_B:    e = 1'b0;
      F3_H:    e = a[0];
      F3_W:    e = |a;
      F3_BU:   e = we;
      F3_HU:   e = we | a[0];
      default: e = 1'b1;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte/halfword lane handling: load extraction with sign/zero extension and
// the merge of sub-word store data into a previously read word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] word,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_val,
  output logic [DATA_W-1:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        unused_wdata_hi;

  assign unused_wdata_hi = ^wdata[31:16];

  // Pick the addressed lane and extend it to a full word.
  always_comb begin
    byte_sel = word[{addr, 3'b000} +: 8];
    half_sel = addr[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    load_val = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_val = {24'h0, byte_sel};
      F3_H:    load_val = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_val = {16'h0, half_sel};
      default: load_val = word;
    endcase
  end

  // Overwrite only the addressed byte/half of the word read back.
  always_comb begin
    merged = word;
    if (funct3 == F3_B) begin
      merged[{addr, 3'b000} +: 8] = wdata[7:0];
    end else if (funct3 == F3_H) begin
      if (addr[1]) merged[31:16] = wdata[15:0];
      else         merged[15:0]  = wdata[15:0];
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store master for a word-organised memory with word-only write
// enable. Sub-word stores are done as read-modify-write.
//
// state  | meaning
// IDLE   | ready for a request
// LOAD   | word address on the bus, read lane captured at next edge
// STORE  | full-word write in progress
// RMW_RD | read old word, merge sub-word data at next edge
// RMW_WR | write merged word
// ERR    | misaligned/illegal request, report error without memory access
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int M_ADDR_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [2:0]          req_funct3,
  input  logic [31:0]         req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic                mem_w_en,
  output logic [M_ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0]   mem_din,
  input  logic [DATA_W-1:0]   mem_dout
);

  lsu_state_e        state, state_nx;
  logic [2:0]        f3_q;
  logic [1:0]        lo_q;
  logic [DATA_W-1:0] wdata_q;
  logic              accept;
  logic              acc_err;
  logic [DATA_W-1:0] load_val;
  logic [DATA_W-1:0] merged;
  logic              unused_addr_hi;

  // Upper byte-address bits beyond the memory depth simply wrap.
  assign unused_addr_hi = ^req_addr[31:M_ADDR_W+2];

  assign accept  = req_valid & req_ready;
  assign acc_err = req_is_err(req_we, req_funct3, req_addr[1:0]);

  lsu_lane_align u_align (
    .funct3   (f3_q),
    .addr     (lo_q),
    .word     (mem_dout),
    .wdata    (wdata_q),
    .load_val (load_val),
    .merged   (merged)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state; ready and write enable decoded from the state register only.
  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    mem_w_en  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (acc_err)                  state_nx = ERR;
          else if (!req_we)             state_nx = LOAD;
          else if (req_funct3 == F3_W)  state_nx = STORE;
          else                          state_nx = RMW_RD;
        end
      end
      LOAD:   state_nx = IDLE;
      STORE: begin
        mem_w_en = 1'b1;
        state_nx = IDLE;
      end
      RMW_RD: state_nx = RMW_WR;
      RMW_WR: begin
        mem_w_en = 1'b1;
        state_nx = IDLE;
      end
      ERR:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Request latching, memory bus registers and the one-cycle response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f3_q       <= 3'b0;
      lo_q       <= 2'b0;
      wdata_q    <= '0;
      mem_addr   <= '0;
      mem_din    <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      if (accept) begin
        f3_q    <= req_funct3;
        lo_q    <= req_addr[1:0];
        wdata_q <= req_wdata;
        // Erroneous requests leave the memory bus untouched.
        if (!acc_err) begin
          mem_addr <= req_addr[M_ADDR_W+1:2];
          if (req_we && req_funct3 == F3_W) mem_din <= req_wdata;
        end
      end
      case (state)
        LOAD: begin
          resp_valid <= 1'b1;
          resp_rdata <= load_val;
        end
        STORE:  resp_valid <= 1'b1;
        RMW_RD: mem_din    <= merged;
        RMW_WR: resp_valid <= 1'b1;
        ERR: begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit with a small word memory model and a response
// scoreboard of {err, rdata} entries.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_w_en;
  logic [15:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];

  logic [31:0] mem [0:15] = '{default: 32'h0};
  wire unused_hi = ^mem_addr[15:4];

  load_store_unit #(.M_ADDR_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_w_en   (mem_w_en),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) if (mem_w_en) mem[mem_addr[3:0]] <= mem_din;
  assign mem_dout = mem[mem_addr[3:0]];

  task automatic drive(input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = d;
  endtask

  // Issue one request from idle (called at a negedge) and observe it.
  // k = 0 is the cycle right after the accepting edge.
  task automatic run_one(input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d,
                         output int lat, output int wen_k, output int wen_n,
                         output logic [31:0] rd, output logic er);
    drive(we, f3, a, d);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = -1; wen_k = -1; wen_n = 0; rd = '0; er = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      if (mem_w_en) begin wen_n++; wen_k = k; end
      if (resp_valid && lat < 0) begin lat = k; rd = resp_rdata; er = resp_err; end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_funct3 = 3'b0; req_addr = '0; req_wdata = '0;
    #12;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got %b exp 0", resp_valid); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL rst_resp_err got %b exp 0", resp_err); end
    checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", resp_rdata); end
    checks++; if (mem_w_en !== 1'b0) begin errors++; $display("FAIL rst_w_en got %b exp 0", mem_w_en); end
    checks++; if (mem_addr !== 16'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", mem_addr); end
    checks++; if (mem_din !== 32'h0) begin errors++; $display("FAIL rst_din got %h exp 0", mem_din); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", req_ready); end
  endtask

  task automatic test_sw_lw;
    int lat, wk, wn; logic [31:0] rd; logic er; logic [32:0] exp;
    exp_q.push_back({1'b0, 32'h0});
    run_one(1'b1, F3_W, 32'h0, 32'h12345678, lat, wk, wn, rd, er);
    exp = exp_q.pop_front();
    checks++; if (lat != 1) begin errors++; $display("FAIL sw_latency got %0d exp 1", lat); end
    checks++; if (wn != 1 || wk != 0) begin errors++; $display("FAIL sw_w_en got n=%0d k=%0d exp n=1 k=0", wn, wk); end
    checks++; if ({er, rd} !== exp) begin errors++; $display("FAIL sw_resp got %h exp %h", {er, rd}, exp); end
    checks++; if (mem[0] !== 32'h12345678) begin errors++; $display("FAIL sw_word0 got %h exp 12345678", mem[0]); end
    exp_q.push_back({1'b0, 32'h12345678});
    run_one(1'b0, F3_W, 32'h0, 32'h0, lat, wk, wn, rd, er);
    exp = exp_q.pop_front();
    checks++; if (lat != 1 || wn != 0) begin errors++; $display("FAIL lw_timing got lat=%0d wen=%0d exp lat=1 wen=0", lat, wn); end
    checks++; if ({er, rd} !== exp) begin errors++; $display("FAIL lw_resp got %h exp %h", {er, rd}, exp); end
  endtask

  task automatic test_sb;
    int lat, wk, wn; logic [31:0] rd; logic er; logic [32:0] exp;
    logic [2:0]  f3s [3] = '{F3_W, F3_B, F3_BU};
    logic [31:0] ads [3] = '{32'h0, 32'h1, 32'h1};
    logic [31:0] exs [3] = '{32'h1234AB78, 32'hFFFFFFAB, 32'h000000AB};
    exp_q.push_back({1'b0, 32'h0});
    run_one(1'b1, F3_B, 32'h1, 32'h000000AB, lat, wk, wn, rd, er);
    exp = exp_q.pop_front();
    checks++; if (lat != 2) begin errors++; $display("FAIL sb_latency got %0d exp 2", lat); end
    checks++; if (wn != 1 || wk != 1) begin errors++; $display("FAIL sb_w_en got n=%0d k=%0d exp n=1 k=1", wn, wk); end
    checks++; if ({er, rd} !== exp) begin errors++; $display("FAIL sb_resp got %h exp %h", {er, rd}, exp); end
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({1'b0, exs[i]});
      run_one(1'b0, f3s[i], ads[i], 32'h0, lat, wk, wn, rd, er);
      exp = exp_q.pop_front();
      checks++;
      if (lat != 1 || {er, rd} !== exp) begin
        errors++; $display("FAIL sb_load%0d got lat=%0d %h exp lat=1 %h", i, lat, {er, rd}, exp);
      end
    end
  endtask

  task automatic test_sh;
    int lat, wk, wn; logic [31:0] rd; logic er; logic [32:0] exp;
    logic [2:0]  f3s [2] = '{F3_H, F3_HU};
    logic [31:0] exs [2] = '{32'hFFFF8001, 32'h00008001};
    exp_q.push_back({1'b0, 32'h0});
    run_one(1'b1, F3_H, 32'h6, 32'hDEAD8001, lat, wk, wn, rd, er);
    exp = exp_q.pop_front();
    checks++; if (lat != 2 || {er, rd} !== exp) begin errors++; $display("FAIL sh_resp got lat=%0d %h exp lat=2 %h", lat, {er, rd}, exp); end
    checks++; if (mem[1] !== 32'h80010000) begin errors++; $display("FAIL sh_word1 got %h exp 80010000", mem[1]); end
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({1'b0, exs[i]});
      run_one(1'b0, f3s[i], 32'h6, 32'h0, lat, wk, wn, rd, er);
      exp = exp_q.pop_front();
      checks++;
      if (lat != 1 || {er, rd} !== exp) begin
        errors++; $display("FAIL sh_load%0d got lat=%0d %h exp lat=1 %h", i, lat, {er, rd}, exp);
      end
    end
  endtask

  task automatic test_errors;
    int lat, wk, wn; logic [31:0] rd; logic er; logic [32:0] exp;
    logic        wes [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0]  f3s [4] = '{F3_W, F3_H, 3'b011, F3_BU};
    logic [31:0] ads [4] = '{32'h2, 32'h3, 32'h0, 32'h0};
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({1'b1, 32'h0});
      run_one(wes[i], f3s[i], ads[i], 32'h0000FFFF, lat, wk, wn, rd, er);
      exp = exp_q.pop_front();
      checks++;
      if (lat != 1 || wn != 0 || {er, rd} !== exp) begin
        errors++; $display("FAIL err%0d got lat=%0d wen=%0d %h exp lat=1 wen=0 %h", i, lat, wn, {er, rd}, exp);
      end
    end
    checks++; if (mem[0] !== 32'h1234AB78) begin errors++; $display("FAIL err_word0 got %h exp 1234AB78", mem[0]); end
  endtask

  task automatic test_reset_mid;
    int bad;
    drive(1'b1, F3_B, 32'h4, 32'h000000FF);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if (mem_addr !== 16'h1) begin errors++; $display("FAIL rmid_addr got %h exp 0001", mem_addr); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_w_en !== 1'b0 || mem_addr !== 16'h0 || mem_din !== 32'h0 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL rmid_outputs got w_en=%b addr=%h din=%h rv=%b exp all 0", mem_w_en, mem_addr, mem_din, resp_valid);
    end
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (resp_valid || mem_w_en) bad++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (resp_valid || mem_w_en) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rmid_activity got %0d exp 0", bad); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got %b exp 1", req_ready); end
    checks++; if (mem[1] !== 32'h80010000) begin errors++; $display("FAIL rmid_word1 got %h exp 80010000", mem[1]); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] ads [4] = '{32'h0, 32'h4, 32'h0, 32'h4};
    logic [31:0] exs [4] = '{32'h1234AB78, 32'h80010000, 32'h1234AB78, 32'h80010000};
    int issued = 0, got = 0;
    logic acc;
    logic [32:0] exp;
    drive(1'b0, F3_W, ads[0], 32'h0);
    for (int c = 0; c < 40 && got < 4; c++) begin
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++; $display("FAIL b2b_spurious got resp %h exp none", resp_rdata);
        end else begin
          exp = exp_q.pop_front();
          checks++;
          if ({resp_err, resp_rdata} !== exp) begin
            errors++; $display("FAIL b2b_resp%0d got %h exp %h", got, {resp_err, resp_rdata}, exp);
          end
        end
        got++;
      end
      acc = req_valid & req_ready;
      @(posedge clk);
      if (acc) begin exp_q.push_back({1'b0, exs[issued]}); issued++; end
      @(negedge clk);
      if (issued < 4) req_addr = ads[issued];
      else            req_valid = 1'b0;
    end
    checks++; if (got != 4 || issued != 4) begin errors++; $display("FAIL b2b_count got %0d/%0d exp 4/4", got, issued); end
  endtask

  initial begin
    test_reset();
    test_sw_lw();
    test_sb();
    test_sh();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
